// File: rtl/load_store_unit.sv
// RV32I load/store sequencer: byte/half/word loads, read-modify-write sub-word stores.
// Define LSU_ALIGN_CHECK_EN to reject misaligned H/HU/SH and W/SW accesses.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic        o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    WR
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        we_q;
  logic        err_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        accept;
  logic        f3_bad;
  logic        misalign;
  logic        reject;
  logic        is_sw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_val;
  logic [31:0] merged;

  assign accept = i_req && (state == IDLE);
  assign f3_bad = (i_funct3 == 3'd3) ||
                  (i_funct3[2:1] == 2'b11);

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign =
    ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
    ((i_funct3[1:0] == 2'b10) &&
     (i_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign reject = f3_bad || misalign;
  assign is_sw  = i_we && (i_funct3[1:0] == 2'b10);

  // Rejected requests ride through WR with the write strobe masked
  assign o_ready   = (state == IDLE);
  assign o_mem_ren = (state == RD);
  assign o_mem_wen = (state == WR) && !err_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reject || is_sw) state_nx = WR;
          else                 state_nx = RD;
        end
      end
      RD:      state_nx = CAP;
      CAP:     state_nx = we_q ? WR : IDLE;
      WR:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = i_mem_rd[7:0];
    case (lane_q)
      2'd0:    byte_sel = i_mem_rd[7:0];
      2'd1:    byte_sel = i_mem_rd[15:8];
      2'd2:    byte_sel = i_mem_rd[23:16];
      2'd3:    byte_sel = i_mem_rd[31:24];
      default: byte_sel = i_mem_rd[7:0];
    endcase
    half_sel = lane_q[1] ? i_mem_rd[31:16]
                         : i_mem_rd[15:0];
  end

  always_comb begin
    ld_val = i_mem_rd;
    unique case (1'b1)
      (f3_q[1:0] == 2'b00):
        ld_val = {{24{~f3_q[2] & byte_sel[7]}},
                  byte_sel};
      (f3_q[1:0] == 2'b01):
        ld_val = {{16{~f3_q[2] & half_sel[15]}},
                  half_sel};
      default:
        ld_val = i_mem_rd;
    endcase
  end

  always_comb begin
    merged = i_mem_rd;
    if (f3_q[1:0] == 2'b00)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else if (lane_q[1])
      merged[31:16] = wdata_q;
    else
      merged[15:0] = wdata_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      f3_q       <= 3'd0;
      lane_q     <= 2'd0;
      wdata_q    <= 16'd0;
      o_rdata    <= 32'd0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_mem_addr <= 32'd0;
      o_mem_wd   <= 32'd0;
    end else begin
      state  <= state_nx;
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (accept) begin
        we_q       <= i_we;
        err_q      <= reject;
        f3_q       <= i_funct3;
        lane_q     <= i_addr[1:0];
        wdata_q    <= i_wdata[15:0];
        o_mem_addr <= {i_addr[31:2], 2'b00};
        if (!reject && is_sw)
          o_mem_wd <= i_wdata;
      end
      if (state == CAP) begin
        if (we_q) begin
          o_mem_wd <= merged;
        end else begin
          o_rdata <= ld_val;
          o_done  <= 1'b1;
        end
      end
      if (state == WR) begin
        o_done <= 1'b1;
        o_err  <= err_q;
        if (err_q)
          o_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word memory model.
// Expectations follow LSU_ALIGN_CHECK_EN when defined.
module tb_load_store_unit;

`ifdef LSU_ALIGN_CHECK_EN
  localparam logic ALN = 1'b1;
`else
  localparam logic ALN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic [31:0] i_mem_rd;
  logic        o_ready;
  logic [31:0] o_rdata;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wd;
  logic        o_mem_wen;
  logic        o_mem_ren;

  load_store_unit dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .o_ready    (o_ready),
    .i_we       (i_we),
    .i_funct3   (i_funct3),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_mem_addr (o_mem_addr),
    .o_mem_wd   (o_mem_wd),
    .o_mem_wen  (o_mem_wen),
    .o_mem_ren  (o_mem_ren),
    .i_mem_rd   (i_mem_rd)
  );

  always #5 i_clk = ~i_clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  logic [31:0] held = 32'd0;
  logic        mem_load = 1'b1;
  logic [31:0] mem [0:15];
  logic [31:0] mem_rd = 32'd0;

  assign i_mem_rd = mem_rd;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h804020F1;
    end else begin
      if (o_mem_ren) mem_rd <= mem[o_mem_addr[5:2]];
      if (o_mem_wen) mem[o_mem_addr[5:2]] <= o_mem_wd;
    end
  end

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        er;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] wd;
  } wexp_t;

  exp_t  sb[$];
  wexp_t wq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge i_clk) begin : mon
    exp_t  e;
    wexp_t w;
    if (!i_rst && !mem_load) begin
      if (o_mem_ren || o_mem_wen) strobes++;
      if (o_mem_wen) begin
        chk("wen_excl_ren", {31'd0, o_mem_ren}, 32'd0);
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wen got wen=1 want 0");
        end else begin
          w = wq.pop_front();
          chk({w.nm, "_maddr"}, o_mem_addr, w.a);
          chk({w.nm, "_mwd"}, o_mem_wd, w.wd);
        end
      end
      if (o_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got done=1 want 0");
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_rdata"}, o_rdata, e.rd);
          chk({e.nm, "_err"}, {31'd0, o_err}, {31'd0, e.er});
          chk({e.nm, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 30) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got 0 want 1");
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || wq.size() != 0) && n < 30) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || wq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got %0d pending want 0",
               sb.size() + wq.size());
      sb.delete();
      wq.delete();
    end
  endtask

  // exp_v: load result for loads, memory write word for stores
  task automatic do_op(input string nm, input logic we,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_v,
                       input logic exp_e);
    exp_t e;
    wexp_t w;
    int s0;
    wait_ready();
    i_req = 1'b1;
    i_we = we;
    i_funct3 = f3;
    i_addr = a;
    i_wdata = wd;
    s0 = strobes;
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
    if (exp_e) held = 32'd0;
    else if (!we) held = exp_v;
    e.nm = nm;
    e.rd = held;
    e.er = exp_e;
    e.acc = cyc;
    if (exp_e) e.lat = 1;
    else if (!we) e.lat = 2;
    else if (f3 == 3'd2) e.lat = 1;
    else e.lat = 3;
    if (!exp_e && we) begin
      w.nm = nm;
      w.a = {a[31:2], 2'b00};
      w.wd = exp_v;
      wq.push_back(w);
    end
    sb.push_back(e);
    drain();
    if (exp_e) chk({nm, "_nostrobe"}, 32'(strobes - s0), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    int n;
    #1 i_rst = 1'b1;
    #2;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_maddr", o_mem_addr, 32'd0);
    chk("rst_mwd", o_mem_wd, 32'd0);
    chk("rst_strb", {30'd0, o_mem_wen, o_mem_ren}, 32'd0);
    repeat (3) @(negedge i_clk);
    #1;
    mem_load = 1'b0;
    i_rst = 1'b0;

    do_op("lb10", 0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFF1, 0);
    do_op("lbu13", 0, 3'd4, 32'h13, 32'h0, 32'h00000080, 0);
    do_op("lh12", 0, 3'd1, 32'h12, 32'h0, 32'hFFFF8040, 0);
    do_op("lhu10", 0, 3'd5, 32'h10, 32'h0, 32'h000020F1, 0);
    do_op("lw12", 0, 3'd2, 32'h12, 32'h0, 32'h804020F1, ALN);

    // reset pulsed while the SH read-modify-write sits in CAP
    wait_ready();
    i_req = 1'b1;
    i_we = 1'b1;
    i_funct3 = 3'd1;
    i_addr = 32'h10;
    i_wdata = 32'h00005555;
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    chk("abort_ready", {31'd0, o_ready}, 32'd1);
    chk("abort_done", {31'd0, o_done}, 32'd0);
    chk("abort_strb", {30'd0, o_mem_wen, o_mem_ren}, 32'd0);
    chk("abort_mwd", o_mem_wd, 32'd0);
    held = 32'd0;
    repeat (2) @(negedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("abort_ready_rel", {31'd0, o_ready}, 32'd1);
    repeat (4) @(negedge i_clk);
    #1;
    chk("abort_word", mem[4], 32'h804020F1);
    do_op("lw_after_abort", 0, 3'd2, 32'h10, 32'h0, 32'h804020F1, 0);

    do_op("sb11", 1, 3'd0, 32'h11, 32'h123456AA, 32'h8040AAF1, 0);
    do_op("lw_sb", 0, 3'd2, 32'h10, 32'h0, 32'h8040AAF1, 0);
    do_op("sw10", 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    do_op("lw_sw", 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    // second request held high through a load, then funct3=7
    wait_ready();
    i_req = 1'b1;
    i_we = 1'b0;
    i_funct3 = 3'd0;
    i_addr = 32'h13;
    @(posedge i_clk);
    #1;
    held = 32'hFFFFFFDE;
    e.nm = "lb13_busy";
    e.rd = held;
    e.er = 1'b0;
    e.acc = cyc;
    e.lat = 2;
    sb.push_back(e);
    i_funct3 = 3'd7;
    i_addr = 32'h10;
    n = 0;
    @(negedge i_clk);
    #1;
    while (!o_ready && n < 30) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
    held = 32'd0;
    e.nm = "f3_7_held";
    e.rd = 32'd0;
    e.er = 1'b1;
    e.acc = cyc;
    e.lat = 1;
    sb.push_back(e);
    drain();

    do_op("sh12", 1, 3'd1, 32'h12, 32'h00001234, 32'h1234BEEF, 0);
    do_op("lh10", 0, 3'd1, 32'h10, 32'h0, 32'hFFFFBEEF, 0);
    do_op("lh11", 0, 3'd1, 32'h11, 32'h0, 32'hFFFFBEEF, ALN);
    do_op("f3_3", 0, 3'd3, 32'h10, 32'h0, 32'h0, 1);
    do_op("f3_6st", 1, 3'd6, 32'h10, 32'hFFFFFFFF, 32'h0, 1);
    do_op("sb13", 1, 3'd0, 32'h13, 32'h0000007F, 32'h7F34BEEF, 0);
    do_op("lb13", 0, 3'd0, 32'h13, 32'h0, 32'h0000007F, 0);
    do_op("lhu12", 0, 3'd5, 32'h12, 32'h0, 32'h00007F34, 0);

    repeat (3) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
